// File: rtl/axi2per_req_channel.sv
// AXI4 slave request front-end: AW/W/AR bursts to 32-bit peripheral requests.
// Define AXI2PER_ATOP_EN to decode AXI lock/ATOP into RISC-V AMO codes.
module axi2per_req_channel #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      axi_slave_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr_i,
  input  logic [7:0]                axi_slave_aw_len_i,
  input  logic [2:0]                axi_slave_aw_size_i,
  input  logic [1:0]                axi_slave_aw_burst_i,
  input  logic                      axi_slave_aw_lock_i,
  input  logic [5:0]                axi_slave_aw_atop_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_slave_aw_user_i,
  output logic                      axi_slave_aw_ready_o,
  input  logic                      axi_slave_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr_i,
  input  logic [7:0]                axi_slave_ar_len_i,
  input  logic [2:0]                axi_slave_ar_size_i,
  input  logic [1:0]                axi_slave_ar_burst_i,
  input  logic                      axi_slave_ar_lock_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_slave_ar_user_i,
  output logic                      axi_slave_ar_ready_o,
  input  logic                      axi_slave_w_valid_i,
  input  logic [63:0]               axi_slave_w_data_i,
  input  logic [7:0]                axi_slave_w_strb_i,
  input  logic                      axi_slave_w_last_i,
  output logic                      axi_slave_w_ready_o,
  output logic                      per_master_req_o,
  output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
  output logic                      per_master_we_o,
  output logic [5:0]                per_master_atop_o,
  output logic [31:0]               per_master_wdata_o,
  output logic [3:0]                per_master_be_o,
  output logic [PER_ID_WIDTH-1:0]   per_master_id_o,
  input  logic                      per_master_gnt_i,
  input  logic                      resp_stall_i,
  output logic                      trans_req_o,
  output logic                      trans_we_o,
  output logic                      trans_last_o,
  output logic                      trans_hi_o,
  output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
  output logic [AXI_USER_WIDTH-1:0] trans_user_o
);

  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_nxt, step;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic                      lock_q;
  logic [5:0]                atop_in_q;
  logic                      hi_q, prio_q;

  logic                      req_q, we_q, beat_end_q, last_q, thi_q;
  logic [PER_ADDR_WIDTH-1:0] add_q;
  logic [5:0]                atop_q;
  logic [31:0]               wdata_q;
  logic [3:0]                be_q;
  logic [PER_ID_WIDTH-1:0]   pid_q;

  logic                      is_rd, is_wr, sz3, act_hi, has_acc, beat_end;
  logic                      issue, granted, empty_beat, beat_done, burst_done;
  logic                      pick_rd, pick_wr, inv;
  logic [3:0]                act_strb, rd_be;
  logic [31:0]               act_data;
  logic [5:0]                amo;
  logic [PER_ADDR_WIDTH-1:0] per_add;

  assign is_rd = state_q == READ;
  assign is_wr = state_q == WRITE;
  assign sz3   = size_q == 3'd3;

  // A 64-bit write skips a half whose strobes are all clear
  assign act_hi   = sz3 ? (hi_q | (is_wr & ~|axi_slave_w_strb_i[3:0]))
                        : addr_q[2];
  assign act_strb = act_hi ? axi_slave_w_strb_i[7:4] : axi_slave_w_strb_i[3:0];
  assign act_data = act_hi ? axi_slave_w_data_i[63:32] : axi_slave_w_data_i[31:0];
  assign has_acc  = is_rd | (|act_strb);
  assign beat_end = ~sz3 | act_hi | (is_wr & ~|axi_slave_w_strb_i[7:4]);

  assign issue      = ~req_q & ~resp_stall_i
                    & (is_rd | (is_wr & axi_slave_w_valid_i & has_acc));
  assign granted    = req_q & per_master_gnt_i;
  assign empty_beat = is_wr & ~req_q & axi_slave_w_valid_i & ~has_acc;
  assign beat_done  = (granted & beat_end_q) | empty_beat;
  assign burst_done = beat_done & (cnt_q == 8'd0);

  assign pick_rd = axi_slave_ar_valid_i & (~axi_slave_aw_valid_i | ~prio_q);
  assign pick_wr = axi_slave_aw_valid_i & ~pick_rd;

  assign axi_slave_ar_ready_o = (state_q == IDLE) & pick_rd;
  assign axi_slave_aw_ready_o = (state_q == IDLE) & pick_wr;
  assign axi_slave_w_ready_o  = (is_wr & granted & beat_end_q) | empty_beat;

  assign step     = AXI_ADDR_WIDTH'(1) << size_q;
  assign addr_nxt = (burst_q == 2'b00) ? addr_q
                  : (addr_q + step) & ~(step - AXI_ADDR_WIDTH'(1));
  assign per_add  = addr_q[PER_ADDR_WIDTH-1:0]
                  | (PER_ADDR_WIDTH'(act_hi) << 2);

  always_comb begin
    rd_be = 4'hF;
    case (size_q)
      3'd0:    rd_be = 4'b0001 << addr_q[1:0];
      3'd1:    rd_be = 4'b0011 << {addr_q[1], 1'b0};
      default: rd_be = 4'hF;
    endcase
  end

`ifdef AXI2PER_ATOP_EN
  logic unused;
  assign unused = ^{axi_slave_w_last_i, addr_q};

  always_comb begin
    amo = '0;
    inv = 1'b0;
    if (is_rd) begin
      if (lock_q) amo = {1'b1, AMO_LR};
    end else if (lock_q) begin
      amo = {1'b1, AMO_SC};
    end else if (atop_in_q == 6'b110000) begin
      amo = {1'b1, AMO_SWAP};
    end else if (atop_in_q[5:3] == 3'b100) begin
      case (atop_in_q[2:0])
        3'b000: amo = {1'b1, AMO_ADD};
        3'b010: amo = {1'b1, AMO_XOR};
        3'b001: begin
          amo = {1'b1, AMO_AND};
          inv = 1'b1;
        end
        3'b011: amo = {1'b1, AMO_OR};
        3'b101: amo = {1'b1, AMO_MIN};
        3'b100: amo = {1'b1, AMO_MAX};
        3'b111: amo = {1'b1, AMO_MINU};
        default: amo = {1'b1, AMO_MAXU};
      endcase
    end
  end
`else
  logic unused;
  assign unused = ^{axi_slave_w_last_i, addr_q, lock_q, atop_in_q};
  assign amo    = '0;
  assign inv    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_rd)      state_d = READ;
        else if (pick_wr) state_d = WRITE;
      end
      READ, WRITE: if (burst_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      user_q       <= '0;
      lock_q       <= 1'b0;
      atop_in_q    <= '0;
      hi_q         <= 1'b0;
      prio_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      beat_end_q   <= 1'b0;
      last_q       <= 1'b0;
      thi_q        <= 1'b0;
      add_q        <= '0;
      atop_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      pid_q        <= '0;
      trans_req_o  <= 1'b0;
      trans_we_o   <= 1'b0;
      trans_last_o <= 1'b0;
      trans_hi_o   <= 1'b0;
      trans_id_o   <= '0;
      trans_user_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        hi_q <= 1'b0;
        if (pick_rd) begin
          addr_q    <= axi_slave_ar_addr_i;
          cnt_q     <= axi_slave_ar_len_i;
          size_q    <= axi_slave_ar_size_i;
          burst_q   <= axi_slave_ar_burst_i;
          id_q      <= axi_slave_ar_id_i;
          user_q    <= axi_slave_ar_user_i;
          lock_q    <= axi_slave_ar_lock_i;
          atop_in_q <= '0;
        end else if (pick_wr) begin
          addr_q    <= axi_slave_aw_addr_i;
          cnt_q     <= axi_slave_aw_len_i;
          size_q    <= axi_slave_aw_size_i;
          burst_q   <= axi_slave_aw_burst_i;
          id_q      <= axi_slave_aw_id_i;
          user_q    <= axi_slave_aw_user_i;
          lock_q    <= axi_slave_aw_lock_i;
          atop_in_q <= axi_slave_aw_atop_i;
        end
      end
      if (issue) begin
        req_q      <= 1'b1;
        add_q      <= per_add;
        we_q       <= is_rd;
        be_q       <= is_rd ? rd_be : act_strb;
        wdata_q    <= is_rd ? 32'h0 : (inv ? ~act_data : act_data);
        atop_q     <= amo;
        pid_q      <= PER_ID_WIDTH'(1) << id_q;
        beat_end_q <= beat_end;
        last_q     <= beat_end & (cnt_q == 8'd0);
        thi_q      <= act_hi;
      end else if (granted) begin
        req_q <= 1'b0;
      end
      if (granted & ~beat_end_q) hi_q <= 1'b1;
      if (beat_done) begin
        addr_q <= addr_nxt;
        hi_q   <= 1'b0;
        cnt_q  <= cnt_q - 8'd1;
        if (burst_done) prio_q <= ~prio_q;
      end
      trans_req_o <= granted;
      if (granted) begin
        trans_we_o   <= ~we_q;
        trans_last_o <= last_q;
        trans_hi_o   <= thi_q;
        trans_id_o   <= id_q;
        trans_user_o <= user_q;
      end
    end
  end

  assign per_master_req_o   = req_q;
  assign per_master_add_o   = add_q;
  assign per_master_we_o    = we_q;
  assign per_master_atop_o  = atop_q;
  assign per_master_wdata_o = wdata_q;
  assign per_master_be_o    = be_q;
  assign per_master_id_o    = pid_q;

endmodule

// File: tb/tb_axi2per_req_channel.sv
// Directed self-checking bench for axi2per_req_channel.
// Honours AXI2PER_ATOP_EN for the atomic-decode expectations.
module tb_axi2per_req_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready, aw_lock;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [5:0]  aw_atop;
  logic [2:0]  aw_id;
  logic [5:0]  aw_user;
  logic        ar_valid, ar_ready, ar_lock;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_id;
  logic [5:0]  ar_user;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        req, we, gnt, stall;
  logic [31:0] add, wdata;
  logic [5:0]  atop;
  logic [3:0]  be;
  logic [4:0]  pid;
  logic        trq, twe, tlast, thi;
  logic [2:0]  tid;
  logic [5:0]  tuser;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi2per_req_channel dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_addr_i(aw_addr),
    .axi_slave_aw_len_i(aw_len), .axi_slave_aw_size_i(aw_size),
    .axi_slave_aw_burst_i(aw_burst), .axi_slave_aw_lock_i(aw_lock),
    .axi_slave_aw_atop_i(aw_atop), .axi_slave_aw_id_i(aw_id),
    .axi_slave_aw_user_i(aw_user), .axi_slave_aw_ready_o(aw_ready),
    .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_addr_i(ar_addr),
    .axi_slave_ar_len_i(ar_len), .axi_slave_ar_size_i(ar_size),
    .axi_slave_ar_burst_i(ar_burst), .axi_slave_ar_lock_i(ar_lock),
    .axi_slave_ar_id_i(ar_id), .axi_slave_ar_user_i(ar_user),
    .axi_slave_ar_ready_o(ar_ready),
    .axi_slave_w_valid_i(w_valid), .axi_slave_w_data_i(w_data),
    .axi_slave_w_strb_i(w_strb), .axi_slave_w_last_i(w_last),
    .axi_slave_w_ready_o(w_ready),
    .per_master_req_o(req), .per_master_add_o(add),
    .per_master_we_o(we), .per_master_atop_o(atop),
    .per_master_wdata_o(wdata), .per_master_be_o(be),
    .per_master_id_o(pid), .per_master_gnt_i(gnt),
    .resp_stall_i(stall),
    .trans_req_o(trq), .trans_we_o(twe), .trans_last_o(tlast),
    .trans_hi_o(thi), .trans_id_o(tid), .trans_user_o(tuser)
  );

  task automatic clear_inputs();
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_size = '0;
    aw_burst = 2'b01; aw_lock = 0; aw_atop = '0; aw_id = '0; aw_user = '0;
    ar_valid = 0; ar_addr = '0; ar_len = '0; ar_size = '0;
    ar_burst = 2'b01; ar_lock = 0; ar_id = '0; ar_user = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0;
    gnt = 0; stall = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (req) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic grant(output logic wr, output logic tr,
                       output logic tw, output logic tl, output logic th);
    gnt = 1; #1;
    wr = w_ready;
    @(negedge clk);
    gnt = 0; #1;
    tr = trq; tw = twe; tl = tlast; th = thi;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req, trq, tlast, ar_ready, aw_ready, w_ready} !== 6'b0 ||
        add !== 32'h0 || atop !== 6'h0 || pid !== 5'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b trq=%b add=%h atop=%h required all 0",
               req, trq, add, atop);
    end
    rst_n = 1;
  endtask

  task automatic test_single_read();
    bit ok;
    logic wr, tr, tw, tl, th;
    @(negedge clk);
    ar_addr = 32'h1000; ar_len = 0; ar_size = 2; ar_id = 2; ar_valid = 1;
    #1;
    checks++;
    if (ar_ready !== 1'b1) begin
      errors++; $display("FAIL rd_ar_ready: got %b want 1", ar_ready);
    end
    @(negedge clk);
    ar_valid = 0; #1;
    checks++;
    if (ar_ready !== 1'b0) begin
      errors++; $display("FAIL rd_ar_ready_pulse: got %b want 0", ar_ready);
    end
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rd_req_timeout: got req=0 want 1");
    end
    checks++;
    if (add !== 32'h1000 || we !== 1'b1 || be !== 4'hF || pid !== 5'b00100) begin
      errors++;
      $display("FAIL rd_fields: got add=%h we=%b be=%h id=%b want 1000 1 f 00100",
               add, we, be, pid);
    end
    grant(wr, tr, tw, tl, th);
    checks++;
    if ({tr, tw, tl, th} !== 4'b1010 || tid !== 3'd2) begin
      errors++;
      $display("FAIL rd_trans: got req/we/last/hi=%b%b%b%b id=%0d want 1010 2",
               tr, tw, tl, th, tid);
    end
    @(negedge clk); #1;
    checks++;
    if (req !== 1'b0 || trq !== 1'b0) begin
      errors++; $display("FAIL rd_idle: got req=%b trq=%b want 0 0", req, trq);
    end
  endtask

  task automatic test_write_burst();
    bit ok;
    logic wr, tr, tw, tl, th;
    logic [31:0] exp;
    @(negedge clk);
    aw_addr = 32'h2000; aw_len = 3; aw_size = 2; aw_burst = 2'b01;
    aw_id = 1; aw_valid = 1;
    w_valid = 1; w_data = {32'hB000_0000, 32'hA000_0000}; w_strb = 8'h0F;
    #1;
    checks++;
    if (aw_ready !== 1'b1) begin
      errors++; $display("FAIL wr_aw_ready: got %b want 1", aw_ready);
    end
    @(negedge clk);
    aw_valid = 0; #1;
    checks++;
    if (aw_ready !== 1'b0) begin
      errors++; $display("FAIL wr_aw_ready_pulse: got %b want 0", aw_ready);
    end
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 32'hA000_0000 + i : 32'hB000_0000 + i;
      wait_req(ok);
      checks++;
      if (!ok || add !== 32'h2000 + 4 * i || we !== 1'b0 ||
          be !== 4'hF || wdata !== exp) begin
        errors++;
        $display("FAIL wr_beat%0d: got req=%b add=%h we=%b be=%h wdata=%h want add=%h we=0 be=f wdata=%h",
                 i, req, add, we, be, wdata, 32'h2000 + 4 * i, exp);
      end
      grant(wr, tr, tw, tl, th);
      checks++;
      if (wr !== 1'b1 || tr !== 1'b1 || tw !== 1'b1 || tl !== (i == 3)) begin
        errors++;
        $display("FAIL wr_grant%0d: got w_ready=%b trq=%b twe=%b last=%b want 1 1 1 %b",
                 i, wr, tr, tw, tl, i == 3);
      end
      w_data = {32'hB000_0000 + i + 1, 32'hA000_0000 + i + 1};
      w_strb = (i % 2 == 0) ? 8'hF0 : 8'h0F;
      if (i == 3) w_valid = 0;
    end
  endtask

  task automatic test_read64();
    bit ok;
    logic wr, tr, tw, tl, th;
    @(negedge clk);
    ar_addr = 32'h3000; ar_len = 1; ar_size = 3; ar_burst = 2'b01;
    ar_id = 0; ar_valid = 1;
    @(negedge clk);
    ar_valid = 0;
    for (int j = 0; j < 4; j++) begin
      wait_req(ok);
      checks++;
      if (!ok || add !== 32'h3000 + 4 * j || we !== 1'b1 || be !== 4'hF) begin
        errors++;
        $display("FAIL rd64_%0d: got req=%b add=%h we=%b be=%h want add=%h we=1 be=f",
                 j, req, add, we, be, 32'h3000 + 4 * j);
      end
      grant(wr, tr, tw, tl, th);
      checks++;
      if (tr !== 1'b1 || th !== j[0] || tl !== (j == 3)) begin
        errors++;
        $display("FAIL rd64_trans%0d: got trq=%b hi=%b last=%b want 1 %b %b",
                 j, tr, th, tl, j[0], j == 3);
      end
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    bit exp_rd;
    logic wr, tr, tw, tl, th;
    test_reset();
    @(negedge clk);
    ar_addr = 32'h4000; ar_len = 0; ar_size = 2; ar_id = 1; ar_valid = 1;
    aw_addr = 32'h5000; aw_len = 0; aw_size = 2; aw_id = 3; aw_valid = 1;
    w_valid = 1; w_data = {32'h0, 32'h1234_5678}; w_strb = 8'h0F;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rd = (k % 2 == 0);
      checks++;
      if (ar_ready !== exp_rd || aw_ready !== !exp_rd) begin
        errors++;
        $display("FAIL arb_pick%0d: got ar_ready=%b aw_ready=%b want %b %b",
                 k, ar_ready, aw_ready, exp_rd, !exp_rd);
      end
      wait_req(ok);
      checks++;
      if (!ok || we !== exp_rd || add !== (exp_rd ? 32'h4000 : 32'h5000)) begin
        errors++;
        $display("FAIL arb_access%0d: got req=%b we=%b add=%h want we=%b",
                 k, req, we, add, exp_rd);
      end
      grant(wr, tr, tw, tl, th);
      if (k == 3) begin
        ar_valid = 0; aw_valid = 0; w_valid = 0;
      end
      checks++;
      if (tr !== 1'b1 || tl !== 1'b1 || tw !== !exp_rd) begin
        errors++;
        $display("FAIL arb_trans%0d: got trq=%b last=%b twe=%b want 1 1 %b",
                 k, tr, tl, tw, !exp_rd);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic wr, tr, tw, tl, th;
    @(negedge clk);
    ar_addr = 32'h6000; ar_len = 1; ar_size = 2; ar_id = 0; ar_valid = 1;
    @(negedge clk);
    ar_valid = 0;
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_req_timeout: got req=0 want 1");
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (req !== 1'b1 || add !== 32'h6000 || be !== 4'hF || pid !== 5'b00001) begin
        errors++;
        $display("FAIL stall_hold%0d: got req=%b add=%h be=%h id=%b want 1 6000 f 00001",
                 c, req, add, be, pid);
      end
    end
    stall = 1; #1;
    checks++;
    if (req !== 1'b1) begin
      errors++; $display("FAIL stall_keep_req: got %b want 1", req);
    end
    grant(wr, tr, tw, tl, th);
    checks++;
    if (tr !== 1'b1 || tl !== 1'b0) begin
      errors++; $display("FAIL stall_grant: got trq=%b last=%b want 1 0", tr, tl);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (req !== 1'b0) begin
        errors++; $display("FAIL stall_block%0d: got req=%b want 0", c, req);
      end
    end
    stall = 0;
    wait_req(ok);
    checks++;
    if (!ok || add !== 32'h6004) begin
      errors++; $display("FAIL stall_resume: got req=%b add=%h want 1 6004", req, add);
    end
    grant(wr, tr, tw, tl, th);
    checks++;
    if (tl !== 1'b1) begin
      errors++; $display("FAIL stall_last: got %b want 1", tl);
    end
  endtask

  task automatic test_atop();
    bit ok;
    logic wr, tr, tw, tl, th;
    logic [5:0]  exp_atop;
    logic [31:0] exp_wdata;
`ifdef AXI2PER_ATOP_EN
    exp_atop = 6'b101100;
    exp_wdata = 32'hFFFF_0000;
`else
    exp_atop = 6'b000000;
    exp_wdata = 32'h0000_FFFF;
`endif
    @(negedge clk);
    aw_addr = 32'h7000; aw_len = 0; aw_size = 2; aw_id = 0;
    aw_atop = 6'h21; aw_lock = 0; aw_valid = 1;
    w_valid = 1; w_data = {32'h0, 32'h0000_FFFF}; w_strb = 8'h0F;
    @(negedge clk);
    aw_valid = 0; aw_atop = 0;
    wait_req(ok);
    checks++;
    if (!ok || atop !== exp_atop || wdata !== exp_wdata || we !== 1'b0 ||
        add !== 32'h7000) begin
      errors++;
      $display("FAIL atop_fields: got req=%b atop=%b wdata=%h we=%b add=%h want atop=%b wdata=%h",
               req, atop, wdata, we, add, exp_atop, exp_wdata);
    end
    grant(wr, tr, tw, tl, th);
    w_valid = 0;
    checks++;
    if (wr !== 1'b1 || tl !== 1'b1) begin
      errors++; $display("FAIL atop_grant: got w_ready=%b last=%b want 1 1", wr, tl);
    end
  endtask

  task automatic test_zero_strobe();
    bit ok;
    logic wr, tr, tw, tl, th;
    @(negedge clk);
    aw_addr = 32'h8000; aw_len = 1; aw_size = 3; aw_burst = 2'b01;
    aw_id = 4; aw_valid = 1;
    w_valid = 1; w_data = {32'hCAFE_0001, 32'h1111_1111}; w_strb = 8'hF0;
    @(negedge clk);
    aw_valid = 0;
    wait_req(ok);
    checks++;
    if (!ok || add !== 32'h8004 || be !== 4'hF || wdata !== 32'hCAFE_0001 ||
        pid !== 5'b10000) begin
      errors++;
      $display("FAIL zs_hi_only: got req=%b add=%h be=%h wdata=%h id=%b want 8004 f cafe0001 10000",
               req, add, be, wdata, pid);
    end
    grant(wr, tr, tw, tl, th);
    checks++;
    if (wr !== 1'b1 || th !== 1'b1 || tl !== 1'b0) begin
      errors++;
      $display("FAIL zs_grant: got w_ready=%b hi=%b last=%b want 1 1 0", wr, th, tl);
    end
    w_strb = 8'h00; #1;
    checks++;
    if (w_ready !== 1'b1 || req !== 1'b0) begin
      errors++;
      $display("FAIL zs_empty_beat: got w_ready=%b req=%b want 1 0", w_ready, req);
    end
    @(negedge clk);
    w_valid = 0; #1;
    checks++;
    if (w_ready !== 1'b0 || req !== 1'b0) begin
      errors++;
      $display("FAIL zs_done: got w_ready=%b req=%b want 0 0", w_ready, req);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    @(negedge clk);
    ar_addr = 32'h9000; ar_len = 3; ar_size = 2; ar_id = 1; ar_valid = 1;
    @(negedge clk);
    ar_valid = 0;
    wait_req(ok);
    checks++;
    if (!ok || add !== 32'h9000) begin
      errors++; $display("FAIL rst_mid_req: got req=%b add=%h want 1 9000", req, add);
    end
    rst_n = 0; #1;
    checks++;
    if (req !== 1'b0 || add !== 32'h0 || be !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_clear: got req=%b add=%h be=%h want 0 0 0", req, add, be);
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (req !== 1'b0 || trq !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_idle%0d: got req=%b trq=%b want 0 0", c, req, trq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_read64();
    test_arbitration();
    test_stall();
    test_atop();
    test_zero_strobe();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
